// File: rtl/param_cfg_sequencer.sv
// param_cfg_sequencer: shadow configuration bank with a freeze, drain,
// atomic-apply commit sequence toward a runtime-loadable datapath.
module param_cfg_sequencer #(
    parameter  int NUM_REGS = 8,
    parameter  int DATA_W   = 32,
    parameter  int TIMEOUT  = 255,
    localparam int ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       commit_req,
    input  logic                       dp_idle,
    output logic                       dp_hold,
    output logic [NUM_REGS*DATA_W-1:0] cfg_active,
    output logic                       cfg_update,
    output logic                       commit_done,
    output logic                       commit_err,
    output logic                       addr_err,
    output logic                       dirty
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [ADDR_W:0]  LP_NREGS = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_APPLY,
        S_ABORT
    } state_t;

    state_t                     r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic [DATA_W-1:0]          r_shadow [NUM_REGS];
    logic [NUM_REGS*DATA_W-1:0] r_cfg;
    logic                       r_wr_ready;
    logic                       r_dp_hold;
    logic                       r_cfg_update;
    logic                       r_commit_done;
    logic                       r_commit_err;
    logic                       r_addr_err;
    logic                       r_dirty;

    state_t                     w_state_nxt;
    logic [CNT_W-1:0]           w_cnt_nxt;
    logic                       w_wr_ready_nxt;
    logic                       w_dp_hold_nxt;
    logic                       w_cfg_update_nxt;
    logic                       w_commit_done_nxt;
    logic                       w_commit_err_nxt;
    logic                       w_addr_err_nxt;
    logic                       w_dirty_nxt;
    logic                       w_apply;
    logic                       w_wr_acc;
    logic                       w_in_range;
    logic                       w_wr_ok;
    logic                       w_wr_bad;

    // Write acceptance: only in IDLE, out-of-range addresses are dropped.
    always_comb begin
        w_in_range = ({1'b0, wr_addr} < LP_NREGS);
        w_wr_acc   = (r_state == S_IDLE) && wr_valid && r_wr_ready;
        w_wr_ok    = w_wr_acc && w_in_range;
        w_wr_bad   = w_wr_acc && !w_in_range;
    end

    // Next-state and next registered-output logic.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_wr_ready_nxt    = r_wr_ready;
        w_dp_hold_nxt     = r_dp_hold;
        w_cfg_update_nxt  = 1'b0;
        w_commit_done_nxt = 1'b0;
        w_commit_err_nxt  = 1'b0;
        w_addr_err_nxt    = 1'b0;
        w_dirty_nxt       = r_dirty;
        w_apply           = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_wr_ready_nxt = 1'b1;
                w_dp_hold_nxt  = 1'b0;
                w_addr_err_nxt = w_wr_bad;
                w_dirty_nxt    = r_dirty | w_wr_ok;
                if (commit_req) begin
                    if (!r_dirty && !w_wr_ok) begin
                        w_commit_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt    = S_DRAIN;
                        w_cnt_nxt      = '0;
                        w_dp_hold_nxt  = 1'b1;
                        w_wr_ready_nxt = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                w_dp_hold_nxt  = 1'b1;
                w_wr_ready_nxt = 1'b0;
                if (dp_idle) begin
                    w_state_nxt = S_APPLY;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == LP_LAST) begin
                        w_state_nxt      = S_ABORT;
                        w_dp_hold_nxt    = 1'b0;
                        w_commit_err_nxt = 1'b1;
                    end
                end
            end
            S_APPLY: begin
                w_apply           = 1'b1;
                w_state_nxt       = S_IDLE;
                w_dirty_nxt       = 1'b0;
                w_dp_hold_nxt     = 1'b0;
                w_wr_ready_nxt    = 1'b1;
                w_cfg_update_nxt  = 1'b1;
                w_commit_done_nxt = 1'b1;
            end
            S_ABORT: begin
                w_state_nxt    = S_IDLE;
                w_dp_hold_nxt  = 1'b0;
                w_wr_ready_nxt = 1'b1;
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_dp_hold_nxt  = 1'b0;
                w_wr_ready_nxt = 1'b1;
            end
        endcase
    end

    // FSM state, wait counter and registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_wr_ready    <= 1'b1;
            r_dp_hold     <= 1'b0;
            r_cfg_update  <= 1'b0;
            r_commit_done <= 1'b0;
            r_commit_err  <= 1'b0;
            r_addr_err    <= 1'b0;
            r_dirty       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_wr_ready    <= w_wr_ready_nxt;
            r_dp_hold     <= w_dp_hold_nxt;
            r_cfg_update  <= w_cfg_update_nxt;
            r_commit_done <= w_commit_done_nxt;
            r_commit_err  <= w_commit_err_nxt;
            r_addr_err    <= w_addr_err_nxt;
            r_dirty       <= w_dirty_nxt;
        end
    end

    // Shadow bank: host writes land here, never directly in the datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_shadow[wr_addr] <= wr_data;
        end
    end

    // Active configuration: whole-bank copy in the single APPLY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg <= '0;
        end else if (w_apply) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cfg[i*DATA_W +: DATA_W] <= r_shadow[i];
            end
        end
    end

    assign wr_ready    = r_wr_ready;
    assign dp_hold     = r_dp_hold;
    assign cfg_active  = r_cfg;
    assign cfg_update  = r_cfg_update;
    assign commit_done = r_commit_done;
    assign commit_err  = r_commit_err;
    assign addr_err    = r_addr_err;
    assign dirty       = r_dirty;

endmodule

// File: tb/tb_param_cfg_sequencer.sv
// tb_param_cfg_sequencer: directed stimulus with a pulse scoreboard
// for the shadow/active configuration sequencer.
module tb_param_cfg_sequencer;

    localparam int NR = 6;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam int AW = 3;
    localparam int CW = NR * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          commit_req;
    logic          dp_idle;
    logic          dp_hold;
    logic [CW-1:0] cfg_active;
    logic          cfg_update;
    logic          commit_done;
    logic          commit_err;
    logic          addr_err;
    logic          dirty;

    param_cfg_sequencer #(
        .NUM_REGS (NR),
        .DATA_W   (DW),
        .TIMEOUT  (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit_req  (commit_req),
        .dp_idle     (dp_idle),
        .dp_hold     (dp_hold),
        .cfg_active  (cfg_active),
        .cfg_update  (cfg_update),
        .commit_done (commit_done),
        .commit_err  (commit_err),
        .addr_err    (addr_err),
        .dirty       (dirty)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic          upd;
        logic          done;
        logic          err;
        logic          aerr;
        logic          dirty;
        logic [CW-1:0] cfg;
    } exp_t;

    exp_t          q[$];
    exp_t          m_e;
    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] m_sh  [NR];
    logic [DW-1:0] m_act [NR];
    logic          m_dirty;

    function automatic logic [CW-1:0] pack_bank(input logic [DW-1:0] b [NR]);
        logic [CW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = b[i];
        return v;
    endfunction

    function automatic exp_t mk(input int c, input logic u, input logic d,
                                input logic e, input logic a,
                                input logic dr, input logic [CW-1:0] cf);
        exp_t r;
        r.cyc = c; r.upd = u; r.done = d; r.err = e;
        r.aerr = a; r.dirty = dr; r.cfg = cf;
        return r;
    endfunction

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && (cfg_update || commit_done || commit_err || addr_err)) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse cyc=%0d upd=%b done=%b err=%b aerr=%b",
                         cyc, cfg_update, commit_done, commit_err, addr_err);
            end else begin
                m_e = q.pop_front();
                if (cyc != m_e.cyc || cfg_update !== m_e.upd ||
                    commit_done !== m_e.done || commit_err !== m_e.err ||
                    addr_err !== m_e.aerr || dirty !== m_e.dirty ||
                    cfg_active !== m_e.cfg) begin
                    failures++;
                    $display("FAIL pulse actual cyc=%0d u/d/e/a/dirty=%b%b%b%b%b cfg=%0h required cyc=%0d u/d/e/a/dirty=%b%b%b%b%b cfg=%0h",
                             cyc, cfg_update, commit_done, commit_err, addr_err, dirty, cfg_active,
                             m_e.cyc, m_e.upd, m_e.done, m_e.err, m_e.aerr, m_e.dirty, m_e.cfg);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [CW-1:0] act,
                       input logic [CW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        wr_valid = 1'b1;
        wr_addr  = AW'(a);
        wr_data  = d;
        if (a < NR) begin
            m_sh[a] = d;
            m_dirty = 1'b1;
        end else begin
            q.push_back(mk(cyc + 1, 0, 0, 0, 1, m_dirty, pack_bank(m_act)));
        end
        step();
        wr_valid = 1'b0;
    endtask

    // idle_at <= 0 means the datapath never goes idle (timeout path).
    task automatic commit(input string name, input int idle_at,
                          input bit with_wr, input int a,
                          input logic [DW-1:0] d, input bit retrig,
                          input int exp_hold);
        int hold;
        int bad;
        int i;
        commit_req = 1'b1;
        dp_idle    = 1'b0;
        if (with_wr) begin
            wr_valid = 1'b1;
            wr_addr  = AW'(a);
            wr_data  = d;
            m_sh[a]  = d;
            m_dirty  = 1'b1;
        end
        if (idle_at > 0) begin
            q.push_back(mk(cyc + idle_at + 2, 1, 1, 0, 0, 0, pack_bank(m_sh)));
            m_act   = m_sh;
            m_dirty = 1'b0;
        end else begin
            q.push_back(mk(cyc + TO + 1, 0, 0, 1, 0, 1, pack_bank(m_act)));
        end
        step();
        commit_req = 1'b0;
        wr_valid   = 1'b0;
        hold = 0;
        bad  = 0;
        i    = 1;
        while (i <= 60) begin
            dp_idle    = (idle_at > 0) && (i >= idle_at);
            commit_req = retrig && (i == 2);
            if (!dp_hold) break;
            hold++;
            if (wr_ready) bad++;
            step();
            i++;
        end
        commit_req = 1'b0;
        dp_idle    = 1'b0;
        chk({name, "_hold_cycles"}, CW'(hold), CW'(exp_hold));
        chk({name, "_wr_ready_in_hold"}, CW'(bad), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold;
        rst_n      = 1'b0;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        commit_req = 1'b0;
        dp_idle    = 1'b0;
        m_dirty    = 1'b0;
        for (int i = 0; i < NR; i++) begin
            m_sh[i]  = '0;
            m_act[i] = '0;
        end
        step();
        step();
        chk("rst_wr_ready", CW'(wr_ready), CW'(1));
        chk("rst_dp_hold", CW'(dp_hold), '0);
        chk("rst_cfg_active", cfg_active, '0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst_pulses_dirty",
            CW'({cfg_update, commit_done, commit_err, addr_err, dirty}), '0);

        wr(3, 32'hDEADBEEF);
        chk("wr_sets_dirty", CW'(dirty), CW'(1));
        chk("wr_cfg_untouched", cfg_active, '0);

        commit("basic", 1, 0, 0, '0, 0, 2);
        chk("basic_dirty_clear", CW'(dirty), '0);

        wr(1, 32'h11111111);
        commit("drain10", 11, 0, 0, '0, 0, 12);

        wr(6, 32'hBAD00006);
        wr(7, 32'hBAD00007);
        chk("addr_err_dirty", CW'(dirty), '0);

        commit("wr_with_commit", 1, 1, 0, 32'd5, 0, 2);

        q.push_back(mk(cyc + 1, 0, 1, 0, 0, 0, pack_bank(m_act)));
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        hold = 0;
        repeat (4) begin
            if (dp_hold) hold++;
            step();
        end
        chk("clean_commit_no_hold", CW'(hold), '0);

        wr(2, 32'h22220002);
        commit("retrig_ignored", 3, 0, 0, '0, 1, 4);

        wr(4, 32'h44440004);
        commit("timeout", 0, 0, 0, '0, 0, TO);
        step();
        chk("timeout_dirty_kept", CW'(dirty), CW'(1));
        chk("timeout_cfg_kept", cfg_active, pack_bank(m_act));

        commit("after_timeout", 1, 0, 0, '0, 0, 2);

        wr(5, 32'h55550005);
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        dp_idle    = 1'b1;
        step();
        chk("apply_hold_high", CW'(dp_hold), CW'(1));
        rst_n = 1'b0;
        #1;
        dp_idle = 1'b0;
        chk("async_rst_hold", CW'(dp_hold), '0);
        chk("async_rst_cfg", cfg_active, '0);
        chk("async_rst_ready_dirty", CW'({wr_ready, dirty}), CW'(2'b10));
        for (int i = 0; i < NR; i++) begin
            m_sh[i]  = '0;
            m_act[i] = '0;
        end
        m_dirty = 1'b0;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();
        chk("post_rst_cfg", cfg_active, '0);
        chk("queue_drained", CW'(q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
